// File: rtl/seg7_scan_driver.sv
// Time-multiplexed NDIG-digit hex driver for a 7-segment display, with a tear-free load/commit handshake.
// Optional feature: define SEG7_LEAD_ZERO_BLANK_EN to blank leading zero digits automatically.
module seg7_scan_driver #(
    parameter int NDIG    = 4,
    parameter int DWELL   = 32,
    parameter bit AN_ACT  = 1'b0,
    parameter bit SEG_ACT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    output logic              ready,
    input  logic [4*NDIG-1:0] data_in,
    input  logic [NDIG-1:0]   blank_in,
    output logic [NDIG-1:0]   an,
    output logic [6:0]        seg,
    output logic              frame_start
);
    localparam int IW = $clog2(NDIG);
    localparam int CW = $clog2(DWELL);
    localparam logic [NDIG-1:0] AN_OFF  = {NDIG{~AN_ACT}};
    localparam logic [6:0]      SEG_OFF = {7{~SEG_ACT}};

    logic [CW-1:0]     cnt_reg;
    logic [IW-1:0]     idx_reg;
    logic              pending_reg;
    logic [4*NDIG-1:0] shadow_reg;
    logic [NDIG-1:0]   shadow_blank_reg;
    logic [4*NDIG-1:0] display_reg;
    logic [NDIG-1:0]   display_blank_reg;

    logic            last_cnt;
    logic            last_idx;
    logic            accept;
    logic            commit;
    logic [3:0]      nib [NDIG];
    logic [NDIG-1:0] an_lit;
    logic [NDIG-1:0] auto_blank;
    logic [NDIG-1:0] blank_eff;
    logic [NDIG-1:0] an_next;
    logic [6:0]      seg_lit;

    // Active-high segment pattern {a,b,c,d,e,f,g} for one hex nibble.
    function automatic logic [6:0] hex_lit(input logic [3:0] v);
        case (v)
            4'h0: hex_lit = 7'h7E;
            4'h1: hex_lit = 7'h30;
            4'h2: hex_lit = 7'h6D;
            4'h3: hex_lit = 7'h79;
            4'h4: hex_lit = 7'h33;
            4'h5: hex_lit = 7'h5B;
            4'h6: hex_lit = 7'h5F;
            4'h7: hex_lit = 7'h70;
            4'h8: hex_lit = 7'h7F;
            4'h9: hex_lit = 7'h7B;
            4'hA: hex_lit = 7'h77;
            4'hB: hex_lit = 7'h1F;
            4'hC: hex_lit = 7'h4E;
            4'hD: hex_lit = 7'h3D;
            4'hE: hex_lit = 7'h4F;
            default: hex_lit = 7'h47;
        endcase
    endfunction

    assign last_cnt = (cnt_reg == CW'(DWELL - 1));
    assign last_idx = (idx_reg == IW'(NDIG - 1));
    assign accept   = load & ready;
    assign commit   = last_cnt & last_idx & pending_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_digit
            assign nib[gi]    = display_reg[4*gi +: 4];
            assign an_lit[gi] = (idx_reg == IW'(gi)) ? AN_ACT : ~AN_ACT;
`ifdef SEG7_LEAD_ZERO_BLANK_EN
            // A digit is a leading zero if it and every digit above it is zero; digit 0 always shows.
            if (gi == 0) begin : g_lz0
                assign auto_blank[gi] = 1'b0;
            end else if (gi == NDIG - 1) begin : g_lztop
                assign auto_blank[gi] = (nib[gi] == 4'h0);
            end else begin : g_lzmid
                assign auto_blank[gi] = (nib[gi] == 4'h0) & auto_blank[gi+1];
            end
`else
            assign auto_blank[gi] = 1'b0;
`endif
        end
    endgenerate

    assign blank_eff = display_blank_reg | auto_blank;
    assign seg_lit   = hex_lit(nib[idx_reg]);

    always_comb begin
        an_next = an_lit;
        if (cnt_reg == '0 || blank_eff[idx_reg]) begin
            an_next = AN_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg           <= '0;
            idx_reg           <= '0;
            pending_reg       <= 1'b0;
            shadow_reg        <= '0;
            shadow_blank_reg  <= '0;
            display_reg       <= '0;
            display_blank_reg <= '0;
            an                <= AN_OFF;
            seg               <= SEG_OFF;
            frame_start       <= 1'b0;
            ready             <= 1'b1;
        end else begin
            cnt_reg <= last_cnt ? '0 : cnt_reg + 1'b1;
            if (last_cnt) begin
                idx_reg <= last_idx ? '0 : idx_reg + 1'b1;
            end
            if (commit) begin
                display_reg       <= shadow_reg;
                display_blank_reg <= shadow_blank_reg;
            end
            if (accept) begin
                shadow_reg       <= data_in;
                shadow_blank_reg <= blank_in;
            end
            pending_reg <= accept | (pending_reg & ~commit);
            // Ready returns one edge after the commit, aligned with frame_start.
            ready       <= ~pending_reg & ~accept;
            frame_start <= (cnt_reg == '0) && (idx_reg == '0);
            an          <= an_next;
            seg         <= (cnt_reg == '0) ? SEG_OFF : (SEG_ACT ? seg_lit : ~seg_lit);
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a frame-position model, plus directed literal checks.
// Honours SEG7_LEAD_ZERO_BLANK_EN when the design is built with it.
module tb_seg7_scan_driver;
    localparam int NDIG  = 4;
    localparam int DW    = 8;
    localparam int FRAME = NDIG * DW;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic        ready;
    logic [15:0] data_in;
    logic [3:0]  blank_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_start;

    int n_checks = 0;
    int n_fail   = 0;

    seg7_scan_driver #(.NDIG(NDIG), .DWELL(DW), .AN_ACT(1'b0), .SEG_ACT(1'b0)) dut (
        .clk(clk), .rst(rst), .load(load), .ready(ready), .data_in(data_in),
        .blank_in(blank_in), .an(an), .seg(seg), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Lit segments {a..g} for hex 0..F.
    logic [6:0] lit [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: position within the frame plus the committed and pending words.
    bit          valid = 1'b0;
    int          pos, ms, mc;
    bit          m_pending, acc, com;
    logic [15:0] m_shadow, m_disp;
    logic [3:0]  m_sblank, m_dblank;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_fs, exp_ready;

    function automatic bit blanked(input int s);
        bit z;
        if (m_dblank[s]) return 1'b1;
`ifdef SEG7_LEAD_ZERO_BLANK_EN
        if (s == 0) return 1'b0;
        z = 1'b1;
        for (int d = s; d < NDIG; d++) if (m_disp[4*d +: 4] != 4'h0) z = 1'b0;
        return z;
`else
        z = 1'b0;
        return z;
`endif
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            exp_an = 4'hF; exp_seg = 7'h7F; exp_fs = 1'b0; exp_ready = 1'b1;
            pos = 0; m_pending = 1'b0; m_shadow = '0; m_sblank = '0; m_disp = '0; m_dblank = '0;
            valid = 1'b1;
        end else if (valid) begin
            ms  = pos / DW;
            mc  = pos % DW;
            acc = load && exp_ready;
            com = (pos == FRAME - 1) && m_pending;
            exp_an    = (mc == 0 || blanked(ms)) ? 4'hF : ~(4'(1) << ms);
            exp_seg   = (mc == 0) ? 7'h7F : ~lit[m_disp[4*ms +: 4]];
            exp_fs    = (pos == 0);
            exp_ready = acc ? 1'b0 : ((pos == 0 && !m_pending) ? 1'b1 : exp_ready);
            if (com) begin m_disp = m_shadow; m_dblank = m_sblank; m_pending = 1'b0; end
            if (acc) begin m_shadow = data_in; m_sblank = blank_in; m_pending = 1'b1; end
            pos = (pos + 1) % FRAME;
        end
    end

    always @(negedge clk) begin
        if (valid) begin
            chk("model_an", 32'(an), 32'(exp_an));
            chk("model_seg", 32'(seg), 32'(exp_seg));
            chk("model_frame_start", 32'(frame_start), 32'(exp_fs));
            chk("model_ready", 32'(ready), 32'(exp_ready));
        end
    end

    task automatic wait_an(input logic [3:0] v, input string nm);
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (an === v) return;
        end
        chk({nm, "_timeout"}, 32'(an), 32'(v));
    endtask

    task automatic wait_ready(input string nm);
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (ready === 1'b1) return;
        end
        chk({nm, "_timeout"}, 32'(ready), 32'd1);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] b);
        load = 1'b1; data_in = d; blank_in = b;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Scan one full frame, recording the seg value seen for each anode pattern.
    logic [6:0] seen [16];
    int dark_hits;
    task automatic scan_frame(input logic [3:0] dark_a, input logic [3:0] dark_b);
        for (int k = 0; k < 16; k++) seen[k] = 7'bx;
        dark_hits = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (an != 4'hF) seen[an] = seg;
            if (an == dark_a || an == dark_b) dark_hits++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; data_in = '0; blank_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_fs", 32'(frame_start), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_dead_fs", 32'(frame_start), 32'd1);
        chk("first_dead_an", 32'(an), 32'hF);
        @(negedge clk);
        chk("first_lit_an", 32'(an), 32'hE);

        do_load(16'h1234, 4'b0000);
        chk("ready_drop", 32'(ready), 32'd0);
        do_load(16'hABCD, 4'b0000);
        wait_ready("commit_1234");
        chk("commit_fs", 32'(frame_start), 32'd1);
        wait_an(4'hE, "d0"); chk("seg_4", 32'(seg), 32'h4C);
        wait_an(4'hD, "d1"); chk("seg_3", 32'(seg), 32'h06);
        wait_an(4'hB, "d2"); chk("seg_2", 32'(seg), 32'h12);
        wait_an(4'h7, "d3"); chk("seg_1", 32'(seg), 32'h4F);

        wait_ready("idle");
        do_load(16'h5678, 4'b0100);
        wait_ready("commit_5678");
        scan_frame(4'hB, 4'hB);
        chk("blank_d2_hits", 32'(dark_hits), 32'd0);
        chk("seg_8", 32'(seen[4'hE]), 32'h00);
        chk("seg_7", 32'(seen[4'hD]), 32'h0F);
        chk("seg_5", 32'(seen[4'h7]), 32'h24);

        do_load(16'h0070, 4'b0000);
        wait_ready("commit_0070");
        scan_frame(4'h7, 4'hB);
        chk("lz_d0", 32'(seen[4'hE]), 32'h01);
        chk("lz_d1", 32'(seen[4'hD]), 32'h0F);
`ifdef SEG7_LEAD_ZERO_BLANK_EN
        chk("lz_dark_hits", 32'(dark_hits), 32'd0);
`else
        chk("lz_d2", 32'(seen[4'hB]), 32'h01);
        chk("lz_d3", 32'(seen[4'h7]), 32'h01);
`endif

        repeat (3) @(negedge clk);
        do_load(16'h9999, 4'b0000);
        rst = 1'b1; load = 1'b1;
        @(negedge clk);
        chk("midrst_an", 32'(an), 32'hF);
        chk("midrst_seg", 32'(seg), 32'h7F);
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_fs", 32'(frame_start), 32'd0);
        rst = 1'b0; load = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            load     = ($urandom_range(0, 3) == 0);
            data_in  = 16'($urandom) & (($urandom_range(0, 2) == 0) ? 16'h00FF : 16'hFFFF);
            blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            rst      = ($urandom_range(0, 699) == 0);
            @(negedge clk);
        end
        rst = 1'b0; load = 1'b0;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
